// File: rtl/adder2_b_pkg.sv
// adder2_b_pkg: shared width constants and result-width helper for the adder
package adder2_b_pkg;
    localparam int ADDER_WIDTH_DEFAULT = 2;
    function automatic int result_width(input int w);
        return w + 1;
    endfunction
endpackage

// File: rtl/adder2_b_full_adder.sv
// full_adder: one combinational cell of the ripple-carry chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder2_b.sv
// adder2_b: ripple-carry adder with carry-in, registered sum, carry-out and signed overflow
module adder2_b
    import adder2_b_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);
    localparam int RW = result_width(WIDTH);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [RW-1:0]    r_res;
    logic             r_ovf;
    assign w_c[0] = Cin;
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        full_adder u_fa (
            .a  (A[g]),
            .b  (B[g]),
            .ci (w_c[g]),
            .s  (w_s[g]),
            .co (w_c[g+1])
        );
    end
    // load the chain result every edge; reset clears it and takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_res <= {w_c[WIDTH], w_s};
            r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end
    assign S    = r_res[WIDTH-1:0];
    assign Cout = r_res[WIDTH];
    assign Ovf  = r_ovf;
endmodule

// File: tb/tb_adder2_b.sv
// tb_adder2_b: scoreboard bench for the 2-bit and 8-bit adder configurations
module tb_adder2_b;
    typedef struct {
        logic [8:0] res;
        logic       ovf;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cin2 = 1'b0, cin8 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [1:0] s2;
    logic [7:0] s8;
    logic       cout2, ovf2, cout8, ovf8;
    exp_t       q2[$];
    exp_t       q8[$];
    int         checks = 0;
    int         failures = 0;

    adder2_b #(.WIDTH(2)) dut (
        .clk(clk), .rst(rst), .Cin(cin2), .A(a2), .B(b2),
        .S(s2), .Cout(cout2), .Ovf(ovf2)
    );

    adder2_b #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .Cin(cin8), .A(a8), .B(b8),
        .S(s8), .Cout(cout8), .Ovf(ovf8)
    );

    always #5 clk = ~clk;

    // monitor: each pushed expectation matches the result visible after the next edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q2.size() != 0) begin
            e = q2.pop_front();
            checks++;
            if ({cout2, s2} !== e.res[2:0] || ovf2 !== e.ovf) begin
                failures++;
                $display("FAIL %s: got cout_s=%b ovf=%b expected cout_s=%b ovf=%b",
                         e.tag, {cout2, s2}, ovf2, e.res[2:0], e.ovf);
            end
        end
        if (q8.size() != 0) begin
            e = q8.pop_front();
            checks++;
            if ({cout8, s8} !== e.res || ovf8 !== e.ovf) begin
                failures++;
                $display("FAIL %s: got cout_s=%h ovf=%b expected cout_s=%h ovf=%b",
                         e.tag, {cout8, s8}, ovf8, e.res, e.ovf);
            end
        end
    end

    task automatic drive2(input logic r, input logic [1:0] a, input logic [1:0] b,
                          input logic c, input logic [2:0] res, input logic ovf,
                          input string tag);
        @(negedge clk);
        rst = r; a2 = a; b2 = b; cin2 = c;
        q2.push_back('{res: {6'd0, res}, ovf: ovf, tag: tag});
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] res, input logic ovf, input string tag);
        @(negedge clk);
        rst = 1'b0; a8 = a; b8 = b; cin8 = c;
        q8.push_back('{res: res, ovf: ovf, tag: tag});
    endtask

    task automatic sweep(input logic c);
        for (int bi = 0; bi < 4; bi++) begin
            for (int ai = 0; ai < 4; ai++) begin
                logic [1:0] av, bv;
                logic [2:0] sum;
                av  = 2'(ai);
                bv  = 2'(bi);
                sum = 3'(ai + bi + int'(c));
                drive2(1'b0, av, bv, c, sum, (av[1] == bv[1]) && (sum[1] != av[1]),
                       $sformatf("sweep_c%0d_%0d+%0d", c, ai, bi));
            end
        end
    endtask

    initial begin
        drive2(1'b1, 2'b11, 2'b11, 1'b1, 3'b000, 1'b0, "reset_edge1");
        drive2(1'b1, 2'b11, 2'b11, 1'b1, 3'b000, 1'b0, "reset_edge2");
        drive2(1'b0, 2'b11, 2'b11, 1'b1, 3'b111, 1'b0, "reset_release");
        drive2(1'b0, 2'b01, 2'b00, 1'b0, 3'b001, 1'b0, "ex_01+00");
        drive2(1'b0, 2'b11, 2'b01, 1'b0, 3'b100, 1'b0, "ex_11+01");
        drive2(1'b0, 2'b10, 2'b10, 1'b0, 3'b100, 1'b1, "ex_10+10");
        drive2(1'b0, 2'b00, 2'b00, 1'b1, 3'b001, 1'b0, "ex_00+00+1");
        drive2(1'b0, 2'b01, 2'b10, 1'b1, 3'b100, 1'b0, "ex_01+10+1");
        drive2(1'b0, 2'b11, 2'b11, 1'b1, 3'b111, 1'b0, "ex_11+11+1");
        sweep(1'b0);
        sweep(1'b1);
        drive2(1'b0, 2'b01, 2'b01, 1'b0, 3'b010, 1'b1, "ovf_01+01");
        drive2(1'b0, 2'b10, 2'b10, 1'b0, 3'b100, 1'b1, "ovf_10+10");
        drive2(1'b0, 2'b11, 2'b01, 1'b0, 3'b100, 1'b0, "ovf_11+01");
        drive2(1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, "b2b_000");
        drive2(1'b0, 2'b11, 2'b11, 1'b1, 3'b111, 1'b0, "b2b_111");
        drive2(1'b0, 2'b01, 2'b00, 1'b0, 3'b001, 1'b0, "b2b_001");
        drive2(1'b0, 2'b11, 2'b11, 1'b0, 3'b110, 1'b0, "cin_toggle_0");
        drive2(1'b0, 2'b11, 2'b11, 1'b1, 3'b111, 1'b0, "cin_toggle_1");
        drive2(1'b1, 2'b11, 2'b11, 1'b1, 3'b000, 1'b0, "mid_reset");
        drive2(1'b0, 2'b01, 2'b01, 1'b1, 3'b011, 1'b1, "after_mid_reset");
        drive8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, "w8_FF+01");
        drive8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, "w8_7F+01");
        drive8(8'h80, 8'h80, 1'b1, 9'h101, 1'b1, "w8_80+80+1");
        repeat (3) @(negedge clk);
        checks++;
        if (q2.size() != 0 || q8.size() != 0) begin
            failures++;
            $display("FAIL drain: pending q2=%0d q8=%0d expected 0", q2.size(), q8.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
